// File: rtl/regfile_sb.sv
// ============================================================================
// regfile_sb : ID-stage register file with EX/MEM/WB forwarding, load-use
//              detection and a long-latency write scoreboard driving one stall.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module regfile_sb #(
  parameter int NREAD  = 2,
  parameter int AW     = 5,
  parameter int DW     = 32,
  parameter int MAX_LT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREAD*AW-1:0] raddr_i,
  input  logic [NREAD-1:0]    rused_i,
  output logic [NREAD*DW-1:0] rdata_o,
  input  logic                ex_we_i,
  input  logic [AW-1:0]       ex_waddr_i,
  input  logic [DW-1:0]       ex_wdata_i,
  input  logic                ex_load_i,
  input  logic                mem_we_i,
  input  logic [AW-1:0]       mem_waddr_i,
  input  logic [DW-1:0]       mem_wdata_i,
  input  logic                wb_we_i,
  input  logic [AW-1:0]       wb_waddr_i,
  input  logic [DW-1:0]       wb_wdata_i,
  input  logic                lt_issue_i,
  input  logic [AW-1:0]       lt_waddr_i,
  input  logic                lt_done_i,
  input  logic [AW-1:0]       lt_done_waddr_i,
  output logic                lt_ready_o,
  output logic [3:0]          lt_count_o,
  output logic                stall_o
);

  localparam int              NREG     = 1 << AW;
  localparam logic [3:0]      C_LT_MAX = 4'(MAX_LT);
  localparam logic [AW-1:0]   C_R0     = '0;

  logic [DW-1:0]   rf_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            w_inc, w_dec;
  logic [NREAD-1:0] w_haz;

  assign lt_ready_o = (cnt_q < C_LT_MAX);
  assign lt_count_o = cnt_q;

  // r0 issues never mark busy, so their retirement is recognised by address.
  assign w_dec = lt_done_i &
                 (busy_q[lt_done_waddr_i] | ((lt_done_waddr_i == C_R0) & (cnt_q != 4'd0)));
  // A retirement in the same cycle frees a slot, so a full scoreboard still accepts.
  assign w_inc = lt_issue_i & (lt_ready_o | w_dec);

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (lt_done_i) busy_d[lt_done_waddr_i] = 1'b0;
    if (w_inc && (lt_waddr_i != C_R0)) busy_d[lt_waddr_i] = 1'b1;
    if (w_inc && !w_dec)      cnt_d = cnt_q + 4'd1;
    else if (!w_inc && w_dec) cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= 4'd0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) rf_q[k] <= '0;
    end else if (wb_we_i && (wb_waddr_i != C_R0)) begin
      rf_q[wb_waddr_i] <= wb_wdata_i;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_port
    logic [AW-1:0] w_a;
    logic          w_lu, w_bh;

    assign w_a = raddr_i[i*AW +: AW];

    assign rdata_o[i*DW +: DW] =
        (w_a == C_R0)                        ? {DW{1'b0}} :
        (ex_we_i  && (ex_waddr_i  == w_a))   ? ex_wdata_i  :
        (mem_we_i && (mem_waddr_i == w_a))   ? mem_wdata_i :
        (wb_we_i  && (wb_waddr_i  == w_a))   ? wb_wdata_i  :
                                               rf_q[w_a];

    assign w_lu = rused_i[i] & (w_a != C_R0) & ex_we_i & ex_load_i & (ex_waddr_i == w_a);
    // Completing write is forwarded from WB this cycle, so it does not stall.
    assign w_bh = rused_i[i] & (w_a != C_R0) & busy_q[w_a] &
                  ~(lt_done_i & (lt_done_waddr_i == w_a));
    assign w_haz[i] = w_lu | w_bh;
  end

  assign stall_o = |w_haz;

endmodule

`default_nettype wire
